// File: rtl/sysctrl_pkg.sv
// Shared definitions for the MCU byte-link system-control slave.
// Holds command codes, status magic bytes, slot id base and frame-state enum.
package sysctrl_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 4;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(15);

  localparam logic [BYTE_W-1:0] CMD_STATUS   = 8'd0;
  localparam logic [BYTE_W-1:0] CMD_LEDS     = 8'd1;
  localparam logic [BYTE_W-1:0] CMD_COLOR    = 8'd2;
  localparam logic [BYTE_W-1:0] CMD_BUTTONS  = 8'd3;
  localparam logic [BYTE_W-1:0] CMD_CFG_WR   = 8'd4;
  localparam logic [BYTE_W-1:0] CMD_IRQ      = 8'd5;
  localparam logic [BYTE_W-1:0] CMD_CFG_RD   = 8'd6;
  localparam logic [BYTE_W-1:0] CMD_IRQ_MASK = 8'd7;

  localparam logic [BYTE_W-1:0] STATUS_MAGIC0 = 8'h5C;
  localparam logic [BYTE_W-1:0] STATUS_MAGIC1 = 8'h42;

  // Slot n answers to ASCII id ID_BASE + n
  localparam logic [BYTE_W-1:0] ID_BASE = 8'h41;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_CMD  = 1'b1
  } frame_state_e;

  function automatic logic [BYTE_W-1:0] bit_rev8(input logic [BYTE_W-1:0] b);
    logic [BYTE_W-1:0] r;
    for (int i = 0; i < int'(BYTE_W); i++) r[i] = b[BYTE_W-1-i];
    return r;
  endfunction

endpackage

// File: rtl/sysctrl_gen_if.sv
// Byte-link bus between the MCU deserialiser (master) and sysctrl_gen (slave).
interface sysctrl_gen_if;
  logic       data_in_strobe;
  logic       data_in_start;
  logic [7:0] data_in;
  logic [7:0] data_out;

  modport master (output data_in_strobe, output data_in_start, output data_in,
                  input  data_out);
  modport slave  (input  data_in_strobe, input  data_in_start, input  data_in,
                  output data_out);
endinterface

// File: rtl/sysctrl_irq.sv
// Masked, edge-latched interrupt controller; bit 0 is the coldboot flag.
// Sources pass two sync flops, then a rising-edge detect feeds the pending register.
module sysctrl_irq #(
  parameter int unsigned INT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [INT_WIDTH-1:0] int_in,
  input  logic                 ack_valid,
  input  logic [INT_WIDTH-1:0] ack_mask,
  input  logic                 mask_we,
  input  logic [INT_WIDTH-1:0] mask_wdata,
  output logic [INT_WIDTH-1:0] pending,
  output logic                 int_out_n
);

  localparam logic [INT_WIDTH-1:0] COLDBOOT = INT_WIDTH'(1);
  localparam logic [INT_WIDTH-1:0] SRC_BITS = ~COLDBOOT;

  logic [INT_WIDTH-1:0] sync1_q, sync2_q, sync3_q;
  logic [INT_WIDTH-1:0] pending_q, pending_d;
  logic [INT_WIDTH-1:0] mask_q;
  logic [INT_WIDTH-1:0] rise, clr;

  // Set has priority over a coincident ack
  always_comb begin
    rise      = sync2_q & ~sync3_q & SRC_BITS;
    clr       = ack_valid ? ack_mask : '0;
    pending_d = (pending_q & ~clr) | rise;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      sync3_q   <= '0;
      pending_q <= COLDBOOT;
      mask_q    <= '1;
    end else begin
      sync1_q   <= int_in;
      sync2_q   <= sync1_q;
      sync3_q   <= sync2_q;
      pending_q <= pending_d;
      if (mask_we) mask_q <= mask_wdata;
    end
  end

  assign pending   = pending_q;
  assign int_out_n = ~|(pending_q & mask_q);

endmodule

// File: rtl/sysctrl_gen.sv
// System-control slave: frame decoder, LEDs, colour, config slots, interrupt controller.
// Define SYSCTRL_CFG_READBACK_EN to implement cmd 6 (config slot readback).
module sysctrl_gen
  import sysctrl_pkg::*;
#(
  parameter logic [7:0]          CORE_ID      = 8'h00,
  parameter int unsigned         NUM_CFG      = 26,
  parameter logic [NUM_CFG*8-1:0] CFG_DEFAULTS = '0,
  parameter int unsigned         INT_WIDTH    = 8,
  parameter int unsigned         LED_COUNT    = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  sysctrl_gen_if.slave           link,
  input  logic [INT_WIDTH-1:0]   int_in,
  output logic                   int_out_n,
  input  logic [1:0]             buttons,
  output logic [LED_COUNT-1:0]   leds,
  output logic [23:0]            color,
  output logic [NUM_CFG*8-1:0]   cfg_values,
  output logic [NUM_CFG-1:0]     cfg_changed
);

  frame_state_e         state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [7:0]           command_q, command_d;
  logic [7:0]           ptr_q, ptr_d;
  logic [7:0]           data_out_q, data_out_d;
  logic [LED_COUNT-1:0] leds_q, leds_d;
  logic [23:0]          color_q, color_d;
  logic [NUM_CFG*8-1:0] cfg_q, cfg_d;
  logic [NUM_CFG-1:0]   cfg_changed_q, cfg_changed_d;

  logic                 ack_valid, mask_we;
  logic [INT_WIDTH-1:0] pending;

  sysctrl_irq #(.INT_WIDTH(INT_WIDTH)) u_irq (
    .clk        (clk),
    .reset_n    (reset_n),
    .int_in     (int_in),
    .ack_valid  (ack_valid),
    .ack_mask   (link.data_in[INT_WIDTH-1:0]),
    .mask_we    (mask_we),
    .mask_wdata (link.data_in[INT_WIDTH-1:0]),
    .pending    (pending),
    .int_out_n  (int_out_n)
  );

  // Frame decode; cnt_q is the index of the data byte being received
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    command_d     = command_q;
    ptr_d         = ptr_q;
    data_out_d    = data_out_q;
    leds_d        = leds_q;
    color_d       = color_q;
    cfg_d         = cfg_q;
    cfg_changed_d = '0;
    ack_valid     = 1'b0;
    mask_we       = 1'b0;

    if (link.data_in_strobe) begin
      if (link.data_in_start) begin
        state_d   = ST_CMD;
        cnt_d     = CNT_W'(1);
        command_d = link.data_in;
      end else if (state_q == ST_CMD) begin
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
        case (command_q)
          CMD_STATUS: begin
            case (cnt_q)
              CNT_W'(1): data_out_d = STATUS_MAGIC0;
              CNT_W'(2): data_out_d = STATUS_MAGIC1;
              CNT_W'(3): data_out_d = CORE_ID;
              default:   data_out_d = 8'h00;
            endcase
          end
          CMD_LEDS: begin
            if (cnt_q == CNT_W'(1)) leds_d = link.data_in[LED_COUNT-1:0];
          end
          CMD_COLOR: begin
            case (cnt_q)
              CNT_W'(1): color_d[15:8]  = bit_rev8(link.data_in);
              CNT_W'(2): color_d[7:0]   = bit_rev8(link.data_in);
              CNT_W'(3): color_d[23:16] = bit_rev8(link.data_in);
              default: ;
            endcase
          end
          CMD_BUTTONS: data_out_d = {6'b0, buttons};
          CMD_CFG_WR: begin
            if (cnt_q == CNT_W'(1)) begin
              ptr_d = link.data_in;
            end else begin
              // Ids outside ID_BASE..ID_BASE+NUM_CFG-1 match no slot
              for (int i = 0; i < int'(NUM_CFG); i++) begin
                if (ptr_q == ID_BASE + 8'(i)) begin
                  cfg_d[i*8 +: 8]  = link.data_in;
                  cfg_changed_d[i] = 1'b1;
                end
              end
              ptr_d = ptr_q + 8'd1;
            end
          end
          CMD_IRQ: begin
            data_out_d = 8'(pending);
            if (cnt_q == CNT_W'(1)) ack_valid = 1'b1;
          end
`ifdef SYSCTRL_CFG_READBACK_EN
          CMD_CFG_RD: begin
            if (cnt_q == CNT_W'(1)) begin
              ptr_d = link.data_in;
            end else begin
              data_out_d = 8'hFF;
              for (int i = 0; i < int'(NUM_CFG); i++) begin
                if (ptr_q == ID_BASE + 8'(i)) data_out_d = cfg_q[i*8 +: 8];
              end
              ptr_d = ptr_q + 8'd1;
            end
          end
`endif
          CMD_IRQ_MASK: begin
            if (cnt_q == CNT_W'(1)) mask_we = 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      command_q     <= '0;
      ptr_q         <= '0;
      data_out_q    <= '0;
      leds_q        <= '0;
      color_q       <= '0;
      cfg_q         <= CFG_DEFAULTS;
      cfg_changed_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      command_q     <= command_d;
      ptr_q         <= ptr_d;
      data_out_q    <= data_out_d;
      leds_q        <= leds_d;
      color_q       <= color_d;
      cfg_q         <= cfg_d;
      cfg_changed_q <= cfg_changed_d;
    end
  end

  assign link.data_out = data_out_q;
  assign leds          = leds_q;
  assign color         = color_q;
  assign cfg_values    = cfg_q;
  assign cfg_changed   = cfg_changed_q;

endmodule

// File: tb/tb_sysctrl_gen.sv
// Directed self-checking bench for sysctrl_gen (default build, 26 slots, 8 IRQ channels).
module tb_sysctrl_gen;

  localparam logic [7:0]  CORE_ID   = 8'hA5;
  localparam int unsigned NUM_CFG   = 26;
  localparam int unsigned INT_WIDTH = 8;
  localparam int unsigned LED_COUNT = 2;

  logic                 clk = 1'b0;
  logic                 reset_n = 1'b0;
  logic [INT_WIDTH-1:0] int_in = '0;
  logic                 int_out_n;
  logic [1:0]           buttons = 2'b00;
  logic [LED_COUNT-1:0] leds;
  logic [23:0]          color;
  logic [NUM_CFG*8-1:0] cfg_values;
  logic [NUM_CFG-1:0]   cfg_changed;

  logic [NUM_CFG*8-1:0] exp_cfg = '0;
  logic [7:0]           exp_dout = 8'h00;
  int                   total = 0;
  int                   bad = 0;

  sysctrl_gen_if bus ();

  sysctrl_gen #(
    .CORE_ID   (CORE_ID),
    .NUM_CFG   (NUM_CFG),
    .CFG_DEFAULTS('0),
    .INT_WIDTH (INT_WIDTH),
    .LED_COUNT (LED_COUNT)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .link       (bus),
    .int_in     (int_in),
    .int_out_n  (int_out_n),
    .buttons    (buttons),
    .leds       (leds),
    .color      (color),
    .cfg_values (cfg_values),
    .cfg_changed(cfg_changed)
  );

  always #5 clk = ~clk;

  // One strobe; returns at the falling edge after the capturing rising edge
  task automatic send(input logic st, input logic [7:0] b);
    @(negedge clk);
    bus.data_in_strobe = 1'b1;
    bus.data_in_start  = st;
    bus.data_in        = b;
    @(negedge clk);
    bus.data_in_strobe = 1'b0;
    bus.data_in_start  = 1'b0;
  endtask

  task automatic test_reset();
    bus.data_in_strobe = 1'b0;
    bus.data_in_start  = 1'b0;
    bus.data_in        = 8'h00;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (bus.data_out !== 8'h00) begin bad++; $display("FAIL reset_dout: got %h want 00", bus.data_out); end
    total++; if (leds !== 2'b00) begin bad++; $display("FAIL reset_leds: got %b want 00", leds); end
    total++; if (color !== 24'h0) begin bad++; $display("FAIL reset_color: got %h want 000000", color); end
    total++; if (cfg_values !== exp_cfg) begin bad++; $display("FAIL reset_cfg: got %h want %h", cfg_values, exp_cfg); end
    total++; if (cfg_changed !== '0) begin bad++; $display("FAIL reset_changed: got %h want 0", cfg_changed); end
    total++; if (int_out_n !== 1'b0) begin bad++; $display("FAIL reset_int: got %b want 0", int_out_n); end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_status();
    logic [7:0] exp [5];
    exp = '{8'h5C, 8'h42, CORE_ID, 8'h00, 8'h00};
    send(1'b1, 8'h00);
    for (int i = 0; i < 5; i++) begin
      send(1'b0, 8'(8'hE0 + i));
      total++; if (bus.data_out !== exp[i]) begin bad++; $display("FAIL status_b%0d: got %h want %h", i + 1, bus.data_out, exp[i]); end
    end
    total++; if (int_out_n !== 1'b0) begin bad++; $display("FAIL status_int: got %b want 0", int_out_n); end
    send(1'b1, 8'h05);
    send(1'b0, 8'h00);
    exp_dout = 8'h01;
    total++; if (bus.data_out !== exp_dout) begin bad++; $display("FAIL coldboot_read: got %h want %h", bus.data_out, exp_dout); end
  endtask

  task automatic test_leds();
    send(1'b1, 8'h01);
    send(1'b0, 8'hFE);
    total++; if (leds !== 2'b10) begin bad++; $display("FAIL leds_b1: got %b want 10", leds); end
    send(1'b0, 8'hFF);
    total++; if (leds !== 2'b10) begin bad++; $display("FAIL leds_b2: got %b want 10", leds); end
  endtask

  task automatic test_cfg_write();
    send(1'b1, 8'h04);
    send(1'b0, "C");
    send(1'b0, 8'h12);
    exp_cfg[2*8 +: 8] = 8'h12;
    total++; if (cfg_changed !== 26'h4) begin bad++; $display("FAIL cfg_pulse2: got %h want 0000004", cfg_changed); end
    total++; if (cfg_values !== exp_cfg) begin bad++; $display("FAIL cfg_slot2: got %h want %h", cfg_values, exp_cfg); end
    @(negedge clk);
    total++; if (cfg_changed !== '0) begin bad++; $display("FAIL cfg_pulse_len: got %h want 0", cfg_changed); end
    send(1'b0, 8'h34);
    exp_cfg[3*8 +: 8] = 8'h34;
    total++; if (cfg_changed !== 26'h8) begin bad++; $display("FAIL cfg_pulse3: got %h want 0000008", cfg_changed); end
    total++; if (cfg_values !== exp_cfg) begin bad++; $display("FAIL cfg_slot3: got %h want %h", cfg_values, exp_cfg); end
  endtask

  task automatic test_cfg_range();
    send(1'b1, 8'h04);
    send(1'b0, "Z");
    send(1'b0, 8'h5A);
    exp_cfg[25*8 +: 8] = 8'h5A;
    total++; if (cfg_changed !== 26'h2000000) begin bad++; $display("FAIL cfg_last_pulse: got %h want 2000000", cfg_changed); end
    send(1'b0, 8'hAA);
    total++; if (cfg_changed !== '0) begin bad++; $display("FAIL cfg_over_pulse: got %h want 0", cfg_changed); end
    total++; if (cfg_values !== exp_cfg) begin bad++; $display("FAIL cfg_over_val: got %h want %h", cfg_values, exp_cfg); end
    send(1'b1, 8'h04);
    send(1'b0, 8'h40);
    send(1'b0, 8'hBB);
    total++; if (cfg_changed !== '0 || cfg_values !== exp_cfg) begin bad++; $display("FAIL cfg_under: got %h/%h want 0/%h", cfg_changed, cfg_values, exp_cfg); end
    send(1'b1, 8'h06);
    send(1'b0, 8'h5B);
    send(1'b0, 8'h00);
`ifdef SYSCTRL_CFG_READBACK_EN
    exp_dout = 8'hFF;
`endif
    total++; if (bus.data_out !== exp_dout) begin bad++; $display("FAIL cfg_rd_over: got %h want %h", bus.data_out, exp_dout); end
`ifdef SYSCTRL_CFG_READBACK_EN
    send(1'b1, 8'h06);
    send(1'b0, "C");
    send(1'b0, 8'h00);
    exp_dout = 8'h12;
    total++; if (bus.data_out !== exp_dout) begin bad++; $display("FAIL cfg_rd_c: got %h want %h", bus.data_out, exp_dout); end
`endif
  endtask

  task automatic test_burst();
    send(1'b1, 8'h04);
    send(1'b0, "A");
    for (int i = 0; i < 18; i++) begin
      send(1'b0, 8'(8'h10 + i));
      exp_cfg[i*8 +: 8] = 8'(8'h10 + i);
      total++; if (cfg_changed !== (NUM_CFG'(1) << i)) begin bad++; $display("FAIL burst_pulse%0d: got %h want %h", i, cfg_changed, NUM_CFG'(1) << i); end
    end
    total++; if (cfg_values !== exp_cfg) begin bad++; $display("FAIL burst_val: got %h want %h", cfg_values, exp_cfg); end
  endtask

  task automatic test_color();
    send(1'b1, 8'h02);
    send(1'b0, 8'h01);
    total++; if (color !== 24'h008000) begin bad++; $display("FAIL color_b1: got %h want 008000", color); end
    send(1'b0, 8'h02);
    send(1'b0, 8'h80);
    total++; if (color !== 24'h018040) begin bad++; $display("FAIL color_b3: got %h want 018040", color); end
    send(1'b0, 8'hFF);
    total++; if (color !== 24'h018040) begin bad++; $display("FAIL color_b4: got %h want 018040", color); end
  endtask

  task automatic test_buttons();
    buttons = 2'b10;
    send(1'b1, 8'h03);
    send(1'b0, 8'h00);
    total++; if (bus.data_out !== 8'h02) begin bad++; $display("FAIL buttons_10: got %h want 02", bus.data_out); end
    buttons = 2'b01;
    send(1'b0, 8'h00);
    exp_dout = 8'h01;
    total++; if (bus.data_out !== exp_dout) begin bad++; $display("FAIL buttons_01: got %h want %h", bus.data_out, exp_dout); end
    buttons = 2'b00;
  endtask

  task automatic test_unknown();
    send(1'b1, 8'h0F);
    send(1'b0, 8'h77);
    send(1'b0, 8'h88);
    total++; if (bus.data_out !== exp_dout) begin bad++; $display("FAIL unknown_hold: got %h want %h", bus.data_out, exp_dout); end
    total++; if (cfg_changed !== '0 || cfg_values !== exp_cfg) begin bad++; $display("FAIL unknown_cfg: got %h want %h", cfg_values, exp_cfg); end
  endtask

  task automatic test_irq();
    send(1'b1, 8'h07);
    send(1'b0, 8'h04);
    total++; if (int_out_n !== 1'b1) begin bad++; $display("FAIL irq_masked: got %b want 1", int_out_n); end
    @(negedge clk);
    int_in = 8'h04;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      total++; if (int_out_n !== (i < 3)) begin bad++; $display("FAIL irq_lat%0d: got %b want %b", i, int_out_n, i < 3); end
    end
    int_in = 8'h00;
    send(1'b1, 8'h05);
    send(1'b0, 8'h04);
    total++; if (bus.data_out !== 8'h05) begin bad++; $display("FAIL irq_read: got %h want 05", bus.data_out); end
    total++; if (int_out_n !== 1'b1) begin bad++; $display("FAIL irq_ack: got %b want 1", int_out_n); end
    // Ack of bit 2 lands on the same edge that latches a new int_in[2] edge
    repeat (4) @(negedge clk);
    send(1'b1, 8'h05);
    int_in = 8'h04;
    repeat (2) @(negedge clk);
    bus.data_in_strobe = 1'b1;
    bus.data_in        = 8'h04;
    @(negedge clk);
    bus.data_in_strobe = 1'b0;
    total++; if (bus.data_out !== 8'h01) begin bad++; $display("FAIL irq_race_read: got %h want 01", bus.data_out); end
    total++; if (int_out_n !== 1'b0) begin bad++; $display("FAIL irq_race_int: got %b want 0", int_out_n); end
    int_in = 8'h00;
    send(1'b1, 8'h05);
    send(1'b0, 8'h05);
    total++; if (bus.data_out !== 8'h05) begin bad++; $display("FAIL irq_race_pend: got %h want 05", bus.data_out); end
    total++; if (int_out_n !== 1'b1) begin bad++; $display("FAIL irq_clear_all: got %b want 1", int_out_n); end
    int_in = 8'h01;
    repeat (5) @(negedge clk);
    int_in = 8'h00;
    send(1'b1, 8'h05);
    send(1'b0, 8'h00);
    total++; if (bus.data_out !== 8'h00) begin bad++; $display("FAIL irq_bit0_ignored: got %h want 00", bus.data_out); end
  endtask

  task automatic test_reset_midframe();
    send(1'b1, 8'h04);
    send(1'b0, "A");
    send(1'b0, 8'h77);
    exp_cfg[7:0] = 8'h77;
    total++; if (cfg_values !== exp_cfg) begin bad++; $display("FAIL mid_pre: got %h want %h", cfg_values, exp_cfg); end
    @(negedge clk);
    reset_n = 1'b0;
    #2;
    exp_cfg = '0;
    total++; if (cfg_values !== exp_cfg) begin bad++; $display("FAIL mid_async: got %h want %h", cfg_values, exp_cfg); end
    @(negedge clk);
    reset_n = 1'b1;
    send(1'b0, "B");
    send(1'b0, 8'h99);
    total++; if (cfg_values !== exp_cfg || cfg_changed !== '0) begin bad++; $display("FAIL mid_ignored: got %h/%h want %h/0", cfg_values, cfg_changed, exp_cfg); end
    total++; if (int_out_n !== 1'b0) begin bad++; $display("FAIL mid_int: got %b want 0", int_out_n); end
    send(1'b1, 8'h05);
    send(1'b0, 8'h00);
    total++; if (bus.data_out !== 8'h01) begin bad++; $display("FAIL mid_coldboot: got %h want 01", bus.data_out); end
  endtask

  initial begin
    test_reset();
    test_status();
    test_leds();
    test_cfg_write();
    test_cfg_range();
    test_burst();
    test_color();
    test_buttons();
    test_unknown();
    test_irq();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
